// File: rtl/comb.sv
//------------------------------------------------------------------------------
// comb : GF(2) multiply of a 4-bit word by (x+1), with a registered copy.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module comb_dff (
  input  logic clk,
  input  logic rst,
  input  logic i_set,
  input  logic i_d,
  output logic o_q
);

  logic w_set;
  logic r_q;

  // Set is qualified by reset so that releasing reset while set is still high
  // produces a rising edge on w_set and the cell presets immediately.
  assign w_set = i_set & rst;

  always_ff @(posedge clk or negedge rst or posedge w_set) begin
    if (!rst) begin
      r_q <= 1'b0;
    end else if (w_set) begin
      r_q <= 1'b1;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

module comb (
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic [3:0] i,
  output logic [4:0] o,
  output logic [4:0] o_q
);

  logic [4:0] w_enc;

  assign w_enc = {i, 1'b0} ^ {1'b0, i};
  assign o     = w_enc;

  genvar b;
  generate
    for (b = 0; b < 5; b++) begin : g_bit
      comb_dff u_dff (
        .clk   (clk),
        .rst   (rst),
        .i_set (set),
        .i_d   (w_enc[b]),
        .o_q   (o_q[b])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_comb.sv
//------------------------------------------------------------------------------
// tb_comb : directed self-checking bench for comb.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_comb;

  logic       clk;
  logic       rst;
  logic       set;
  logic [3:0] i;
  logic [4:0] o;
  logic [4:0] o_q;

  int n_checks;
  int n_fail;

  logic [4:0] c_tbl [16];

  comb u_dut (
    .clk (clk),
    .rst (rst),
    .set (set),
    .i   (i),
    .o   (o),
    .o_q (o_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    c_tbl[0]  = 5'b00000; c_tbl[1]  = 5'b00011; c_tbl[2]  = 5'b00110; c_tbl[3]  = 5'b00101;
    c_tbl[4]  = 5'b01100; c_tbl[5]  = 5'b01111; c_tbl[6]  = 5'b01010; c_tbl[7]  = 5'b01001;
    c_tbl[8]  = 5'b11000; c_tbl[9]  = 5'b11011; c_tbl[10] = 5'b11110; c_tbl[11] = 5'b11101;
    c_tbl[12] = 5'b10100; c_tbl[13] = 5'b10111; c_tbl[14] = 5'b10010; c_tbl[15] = 5'b10001;
    n_checks = 0;
    n_fail   = 0;

    // Held in reset with the clock running.
    rst = 1'b0;
    set = 1'b0;
    i   = 4'd5;
    #1;
    chk("rst_oq_init", o_q, 5'b00000);
    chk("rst_o_follows", o, 5'b01111);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_oq_hold", o_q, 5'b00000);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_release_no_edge", o_q, 5'b00000);
    @(posedge clk); #1;
    chk("rst_first_edge", o_q, 5'b01111);

    // Combinational encoding for every code.
    for (int k = 0; k < 16; k++) begin
      i = 4'(k);
      #1;
      chk($sformatf("o_code%0d", k), o, c_tbl[k]);
    end

    // One cycle latency from i to o_q.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      i = 4'(k);
      @(posedge clk); #1;
      chk($sformatf("oq_code%0d", k), o_q, c_tbl[k]);
    end

    // Asynchronous preset pulse between edges.
    @(negedge clk);
    i = 4'd0;
    @(posedge clk); #1;
    chk("set_pre", o_q, 5'b00000);
    #2;
    set = 1'b1;
    #1;
    chk("set_immediate", o_q, 5'b11111);
    @(posedge clk); #1;
    chk("set_over_edge", o_q, 5'b11111);
    @(negedge clk);
    set = 1'b0;
    #1;
    chk("set_fall_hold", o_q, 5'b11111);
    @(posedge clk); #1;
    chk("set_next_edge", o_q, 5'b00000);

    // Reset mid-cycle clears at once.
    @(negedge clk);
    i = 4'd15;
    @(posedge clk); #1;
    chk("midrst_pre", o_q, 5'b10001);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_async", o_q, 5'b00000);
    chk("midrst_o", o, 5'b10001);

    // Reset and preset together: reset wins, then preset takes over.
    set = 1'b1;
    #1;
    chk("both_rst_wins", o_q, 5'b00000);
    @(posedge clk); #1;
    chk("both_over_edge", o_q, 5'b00000);
    #2;
    rst = 1'b1;
    #1;
    chk("both_rst_release", o_q, 5'b11111);
    @(negedge clk);
    set = 1'b0;
    @(posedge clk); #1;
    chk("both_resume", o_q, 5'b10001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
